fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the five-stage core. It owns the fetch PC and issues requests to a variable-latency instruction memory. It holds a request's address stable until the response arrives. Each returned instruction, with its PC and PC+4, is delivered to the fetch/decode pipeline register through explicit enable/clear controls, honouring decode stalls and execute-stage redirects.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  input  1  core clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- imem_req  output  1  fetch request; held high until imem_rvalid
- imem_addr  output  32  fetch address; stable while imem_req high
- imem_rvalid  input  1  response valid; may be high in the same cycle as imem_req (zero wait)
- imem_rdata  input  32  instruction word, valid with imem_rvalid
- redirect  input  1  taken branch/jump from execute
- redirect_pc  input  32  target address, valid with redirect
- stall_d  input  1  hazard unit holds the F/D register
- instr_f  output  32  instruction to F/D register
- pcf  output  32  PC of instr_f
- pc_plus_4f  output  32  pcf + 4, modulo 2^32
- fd_en  output  1  F/D register loads instr_f/pcf/pc_plus_4f
- fd_clr  output  1  F/D register loads zero bubble; overrides fd_en
- perf_wait_cnt  output  32  memory-wait cycle count (see Configuration)

## Operation
- States: BOOT, REQ, HOLD, DISCARD.
- **BOOT**: entered on reset for exactly one cycle. No request. fd_clr=1. Next state is REQ.
- **REQ**: imem_req=1 and imem_addr=pc.
  - Transfer happens when imem_rvalid=1.
  - On transfer with stall_d=0: fd_en=1 with instr_f=imem_rdata, pcf=pc. pc<=pc+4. Stay in REQ.
  - On transfer with stall_d=1: capture the word into the skid buffer. pc<=pc+4. Go to HOLD.
  - No transfer and stall_d=0: fd_clr=1 (bubble).
- **HOLD**: imem_req=0. Outputs come from the skid buffer. fd_en=1 when stall_d=0, then go to REQ.
- **DISCARD**: a request was abandoned while in flight. imem_req stays 1 at the old address. When imem_rvalid arrives, the data is dropped and the state goes to REQ. fd_clr=1 on every non-stalled cycle.
- **redirect** has priority over all else.
  - fd_clr=1 in the same cycle (even if stall_d=1), and pc<=redirect_pc.
  - In REQ without rvalid: go to DISCARD. In REQ with rvalid: data is dropped and state goes to REQ.
  - In HOLD: the buffer is dropped and state goes to REQ.
  - In DISCARD: the target is updated and the state stays DISCARD unless rvalid is high, in which case it goes to REQ.
- When stall_d=1 and redirect=0: fd_en=0 and fd_clr=0.
- PC arithmetic is 32-bit and wraps from 32'hFFFF_FFFC to 0. Bits [1:0] are passed through unchecked.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr_f=0, pcf=0, pc_plus_4f=0, fd_en=0, fd_clr=1, perf_wait_cnt=0, state BOOT.
- First request goes out in cycle 1 after rst_n deasserts.
- fd_en, fd_clr and instr_f are combinational from state, imem_rvalid, stall_d and redirect. There is no extra latency.
- With zero-wait memory and no stalls, throughput is 1 instruction/cycle.
- Redirect penalty: the new-target request is issued the cycle after redirect, or the cycle after the discarded response arrives.
- Asserting rst_n low mid-request abandons it immediately. The memory must tolerate imem_req dropping.

## Configuration
- FETCH_CTRL_PERF_EN defined: perf_wait_cnt counts cycles with imem_req=1 and imem_rvalid=0 (REQ or DISCARD). It saturates at 32'hFFFF_FFFF and is cleared only by reset.
- Not defined: no counter logic; perf_wait_cnt is tied to 0.

## Structure
- Shared package `core_pkg`: `fetch_state_t` enum (BOOT, REQ, HOLD, DISCARD), `XLEN=32`, `NOP_BUBBLE=32'd0`.
- One sub-module, `fetch_skid`: a 1-entry buffer holding instr/pc/pc+4, with load, clear and valid.
- The FSM and PC register stay in `fetch_ctrl`.

## Test plan
- Reset with RESET_PC=32'h100 and zero-wait memory -> requests at 0x100, 0x104, 0x108 on consecutive cycles; fd_en=1 each cycle; pc_plus_4f=pcf+4.
- Memory with 2 wait cycles -> 2 bubble cycles (fd_clr=1) per instruction; perf_wait_cnt increments 2 per fetch with the macro defined, stays 0 without it.
- stall_d=1 for 3 cycles while a response returns -> enter HOLD; the word is delivered exactly once after the stall; the next request goes to pc+4.
- redirect to 0x400 while a request to 0x20 is waiting -> DISCARD; the stale response is dropped; the next request is 0x400; fd_clr=1 throughout.
- redirect and stall_d in the same cycle, in HOLD -> fd_clr=1, buffer dropped, next request at the target.
- pc=32'hFFFF_FFFC -> pc_plus_4f=0 and the next request address is 0.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the five-stage core's fetch logic.
//   fetch_state_t : fetch sequencer states (BOOT, REQ, HOLD, DISCARD)
//   XLEN          : datapath / address width
//   NOP_BUBBLE    : word presented to the F/D register when nothing is valid
//   pc_inc()      : sequential next-PC, wraps modulo 2^XLEN
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_BUBBLE = 32'd0;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_t;

    // Bits [1:0] ride along untouched; the carry out of bit 31 is dropped.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
// Instruction-memory request/response bus between the fetch sequencer and
// a variable-latency instruction memory.
//   req    : fetch request, held high until rvalid
//   addr   : fetch address, stable while req is high
//   rvalid : response valid, may coincide with the first cycle of req
//   rdata  : instruction word, valid with rvalid
// Modports: master (fetch side), slave (memory side).
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    import core_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );

endinterface

// File: rtl/fetch_skid.sv
// -----------------------------------------------------------------------------
// fetch_skid
// One-entry buffer that parks a fetched instruction with its PC and PC+4
// while decode is stalled.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture instr_in / pc_in (pc+4 is derived here)
//   clear               : drop the entry; wins over load
//   instr_in, pc_in     : word and its address to capture
//   instr_out, pc_out,
//   pc_plus_4_out       : buffered entry
//   valid               : entry holds an undelivered instruction
// -----------------------------------------------------------------------------
module fetch_skid
    import core_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    output logic [XLEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_plus_4_out,
    output logic            valid
);

    logic            valid_reg;
    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] pc_plus_4_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg     <= 1'b0;
            instr_reg     <= NOP_BUBBLE;
            pc_reg        <= '0;
            pc_plus_4_reg <= '0;
        end else if (clear) begin
            valid_reg     <= 1'b0;
            instr_reg     <= NOP_BUBBLE;
            pc_reg        <= '0;
            pc_plus_4_reg <= '0;
        end else if (load) begin
            valid_reg     <= 1'b1;
            instr_reg     <= instr_in;
            pc_reg        <= pc_in;
            pc_plus_4_reg <= pc_inc(pc_in);
        end
    end

    assign instr_out     = instr_reg;
    assign pc_out        = pc_reg;
    assign pc_plus_4_out = pc_plus_4_reg;
    assign valid         = valid_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction-fetch sequencer. Owns the fetch PC, issues requests to a
// variable-latency instruction memory and feeds the F/D pipeline register
// through fd_en / fd_clr, honouring decode stalls and execute redirects.
// Parameters:
//   RESET_PC      : first fetch address after reset
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   imem          : instruction memory bus (fetch_ctrl_if.master)
//   redirect      : taken branch/jump from execute, highest priority
//   redirect_pc   : redirect target
//   stall_d       : decode holds the F/D register
//   instr_f, pcf,
//   pc_plus_4f    : instruction, its PC and PC+4 for the F/D register
//   fd_en         : F/D register loads instr_f / pcf / pc_plus_4f
//   fd_clr        : F/D register loads a bubble (overrides fd_en)
//   perf_wait_cnt : saturating count of cycles spent waiting on memory
// Optional feature macro: FETCH_CTRL_PERF_EN enables perf_wait_cnt;
// without it the output is tied to zero.
// -----------------------------------------------------------------------------
module fetch_ctrl
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_ctrl_if.master    imem,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall_d,
    output logic [XLEN-1:0] instr_f,
    output logic [XLEN-1:0] pcf,
    output logic [XLEN-1:0] pc_plus_4f,
    output logic            fd_en,
    output logic            fd_clr,
    output logic [XLEN-1:0] perf_wait_cnt
);

    fetch_state_t    state_reg;
    logic [XLEN-1:0] pc_reg;
    // Address of an abandoned request; the memory still sees it until the
    // stale response comes back, while pc_reg already holds the new target.
    logic [XLEN-1:0] discard_addr_reg;

    logic            skid_load;
    logic            skid_clear;
    logic            skid_valid;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;
    logic [XLEN-1:0] skid_pc_plus_4;
    logic [XLEN-1:0] pc_plus_4;

    assign pc_plus_4 = pc_inc(pc_reg);

    fetch_skid u_skid (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (skid_load),
        .clear         (skid_clear),
        .instr_in      (imem.rdata),
        .pc_in         (pc_reg),
        .instr_out     (skid_instr),
        .pc_out        (skid_pc),
        .pc_plus_4_out (skid_pc_plus_4),
        .valid         (skid_valid)
    );

    // -------------------------------------------------------------------------
    // Sequencer state and fetch PC
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= BOOT;
            pc_reg           <= RESET_PC;
            discard_addr_reg <= RESET_PC;
        end else begin
            case (state_reg)
                BOOT: begin
                    state_reg <= REQ;
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                    end
                end

                REQ: begin
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                        // A response in this same cycle closes the old
                        // request, so the target can be requested at once.
                        if (!imem.rvalid) begin
                            state_reg        <= DISCARD;
                            discard_addr_reg <= pc_reg;
                        end
                    end else if (imem.rvalid) begin
                        pc_reg <= pc_plus_4;
                        if (stall_d) begin
                            state_reg <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_reg    <= redirect_pc;
                        state_reg <= REQ;
                    end else if (!stall_d) begin
                        state_reg <= REQ;
                    end
                end

                DISCARD: begin
                    if (redirect) begin
                        pc_reg <= redirect_pc;
                    end
                    if (imem.rvalid) begin
                        state_reg <= REQ;
                    end
                end

                default: state_reg <= BOOT;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Memory request and F/D controls (combinational, no added latency)
    // -------------------------------------------------------------------------
    always_comb begin
        imem.req   = 1'b0;
        imem.addr  = pc_reg;
        instr_f    = NOP_BUBBLE;
        pcf        = '0;
        pc_plus_4f = '0;
        fd_en      = 1'b0;
        fd_clr     = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;

        case (state_reg)
            BOOT: begin
                fd_clr = 1'b1;
            end

            REQ: begin
                imem.req   = 1'b1;
                instr_f    = imem.rdata;
                pcf        = pc_reg;
                pc_plus_4f = pc_plus_4;
                if (redirect) begin
                    fd_clr = 1'b1;
                end else if (imem.rvalid && !stall_d) begin
                    fd_en = 1'b1;
                end else if (imem.rvalid) begin
                    skid_load = 1'b1;
                end else if (!stall_d) begin
                    fd_clr = 1'b1;
                end
            end

            HOLD: begin
                instr_f    = skid_instr;
                pcf        = skid_pc;
                pc_plus_4f = skid_pc_plus_4;
                if (redirect) begin
                    fd_clr     = 1'b1;
                    skid_clear = 1'b1;
                end else if (!stall_d) begin
                    fd_en      = skid_valid;
                    skid_clear = 1'b1;
                end
            end

            DISCARD: begin
                imem.req  = 1'b1;
                imem.addr = discard_addr_reg;
                fd_clr    = redirect || !stall_d;
            end

            default: begin
                fd_clr = 1'b1;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Memory-wait performance counter
    // -------------------------------------------------------------------------
`ifdef FETCH_CTRL_PERF_EN
    logic [XLEN-1:0] perf_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_reg <= '0;
        end else if (imem.req && !imem.rvalid && (perf_cnt_reg != '1)) begin
            perf_cnt_reg <= perf_cnt_reg + 32'd1;
        end
    end

    assign perf_wait_cnt = perf_cnt_reg;
`else
    assign perf_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
// Directed vector table for the documented corner cases, then a long
// randomized run against a transaction-level model: delivered instructions
// must form the program-order PC stream (sequential, or the latest redirect
// target), each carrying the memory word for its PC.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall_d = 1'b0;
    logic [31:0] instr_f;
    logic [31:0] pcf;
    logic [31:0] pc_plus_4f;
    logic        fd_en;
    logic        fd_clr;
    logic [31:0] perf_wait_cnt;

    fetch_ctrl_if imem ();

    fetch_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .stall_d       (stall_d),
        .instr_f       (instr_f),
        .pcf           (pcf),
        .pc_plus_4f    (pc_plus_4f),
        .fd_en         (fd_en),
        .fd_clr        (fd_clr),
        .perf_wait_cnt (perf_wait_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory contents are a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] perf_expect(input int waits);
`ifdef FETCH_CTRL_PERF_EN
        return 32'(waits);
`else
        return (waits < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
    endfunction

    typedef struct {
        logic        stall;
        logic        redir;
        logic [31:0] tgt;
        logic        rv;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_en;
        logic        exp_clr;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t v(input int s, input int r, input logic [31:0] t, input int rv,
                               input int q, input logic [31:0] a, input int en, input int clr,
                               input logic [31:0] p);
        vec_t x;
        x.stall = s[0]; x.redir = r[0]; x.tgt = t; x.rv = rv[0];
        x.exp_req = q[0]; x.exp_addr = a; x.exp_en = en[0]; x.exp_clr = clr[0]; x.exp_pc = p;
        return x;
    endfunction

    // Reset mid-flight, check reset values, release, check the BOOT cycle.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; stall_d = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        imem.rvalid = 1'b0; imem.rdata = 32'h0;
        #1;
        chk("rst_req", {31'h0, imem.req}, 32'h0);
        chk("rst_addr", imem.addr, RST_PC);
        chk("rst_instr", instr_f, 32'h0);
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_pc4", pc_plus_4f, 32'h0);
        chk("rst_en", {31'h0, fd_en}, 32'h0);
        chk("rst_clr", {31'h0, fd_clr}, 32'h1);
        chk("rst_perf", perf_wait_cnt, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'h0, imem.req}, 32'h0);
        chk("boot_en", {31'h0, fd_en}, 32'h0);
        chk("boot_clr", {31'h0, fd_clr}, 32'h1);
    endtask

    vec_t vecs[$];

    initial begin
        int dir_waits;
        int rnd_waits;
        int delivered;
        int wcnt;
        int lat;
        logic [31:0] exp_pc;
        logic        pend;
        logic [31:0] pend_addr;
        logic        rv;

        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;

        // stall redir target rvalid | req addr en clr pcf
        vecs.push_back(v(0,0,32'h0,1,         1,32'h100,1,0,32'h100));      // zero-wait stream
        vecs.push_back(v(0,0,32'h0,1,         1,32'h104,1,0,32'h104));
        vecs.push_back(v(0,0,32'h0,1,         1,32'h108,1,0,32'h108));
        vecs.push_back(v(0,0,32'h0,0,         1,32'h10C,0,1,32'h0));        // two wait cycles
        vecs.push_back(v(0,0,32'h0,0,         1,32'h10C,0,1,32'h0));
        vecs.push_back(v(0,0,32'h0,1,         1,32'h10C,1,0,32'h10C));
        vecs.push_back(v(1,0,32'h0,1,         1,32'h110,0,0,32'h0));        // stalled response -> HOLD
        vecs.push_back(v(1,0,32'h0,0,         0,32'h0,0,0,32'h0));
        vecs.push_back(v(1,0,32'h0,0,         0,32'h0,0,0,32'h0));
        vecs.push_back(v(0,0,32'h0,0,         0,32'h0,1,0,32'h110));        // delivered once
        vecs.push_back(v(0,0,32'h0,1,         1,32'h114,1,0,32'h114));
        vecs.push_back(v(0,1,32'h20,1,        1,32'h118,0,1,32'h0));        // redirect with rvalid
        vecs.push_back(v(0,0,32'h0,0,         1,32'h20,0,1,32'h0));
        vecs.push_back(v(0,1,32'h400,0,       1,32'h20,0,1,32'h0));         // redirect while waiting
        vecs.push_back(v(0,0,32'h0,0,         1,32'h20,0,1,32'h0));
        vecs.push_back(v(0,0,32'h0,1,         1,32'h20,0,1,32'h0));         // stale response dropped
        vecs.push_back(v(0,0,32'h0,1,         1,32'h400,1,0,32'h400));
        vecs.push_back(v(1,0,32'h0,1,         1,32'h404,0,0,32'h0));        // into HOLD
        vecs.push_back(v(1,1,32'h800,0,       0,32'h0,0,1,32'h0));          // redirect+stall in HOLD
        vecs.push_back(v(0,0,32'h0,1,         1,32'h800,1,0,32'h800));
        vecs.push_back(v(0,1,32'hFFFF_FFFC,0, 1,32'h804,0,1,32'h0));
        vecs.push_back(v(0,0,32'h0,1,         1,32'h804,0,1,32'h0));
        vecs.push_back(v(0,0,32'h0,1,         1,32'hFFFF_FFFC,1,0,32'hFFFF_FFFC)); // wrap
        vecs.push_back(v(0,0,32'h0,1,         1,32'h0,1,0,32'h0));
        vecs.push_back(v(0,1,32'h40,0,        1,32'h4,0,1,32'h0));
        vecs.push_back(v(1,0,32'h0,0,         1,32'h4,0,0,32'h0));          // stalled DISCARD
        vecs.push_back(v(1,1,32'h80,0,        1,32'h4,0,1,32'h0));          // retarget in DISCARD
        vecs.push_back(v(0,0,32'h0,1,         1,32'h4,0,1,32'h0));
        vecs.push_back(v(0,0,32'h0,1,         1,32'h80,1,0,32'h80));
        vecs.push_back(v(1,0,32'h0,0,         1,32'h84,0,0,32'h0));         // stalled wait
        vecs.push_back(v(0,0,32'h0,1,         1,32'h84,1,0,32'h84));

        // ---------------- directed table ----------------
        do_reset();
        dir_waits = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            stall_d     = vecs[i].stall;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].tgt;
            imem.rvalid = vecs[i].rv;
            imem.rdata  = mem_word(imem.addr);
            #1;
            chk($sformatf("v%0d_req", i), {31'h0, imem.req}, {31'h0, vecs[i].exp_req});
            if (vecs[i].exp_req)
                chk($sformatf("v%0d_addr", i), imem.addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_en", i), {31'h0, fd_en}, {31'h0, vecs[i].exp_en});
            chk($sformatf("v%0d_clr", i), {31'h0, fd_clr}, {31'h0, vecs[i].exp_clr});
            if (vecs[i].exp_en) begin
                chk($sformatf("v%0d_pcf", i), pcf, vecs[i].exp_pc);
                chk($sformatf("v%0d_instr", i), instr_f, mem_word(vecs[i].exp_pc));
                chk($sformatf("v%0d_pc4", i), pc_plus_4f, vecs[i].exp_pc + 32'd4);
            end
            if (vecs[i].exp_req && !vecs[i].rv)
                dir_waits++;
        end
        #1;
        chk("dir_perf", perf_wait_cnt, perf_expect(dir_waits));

        // ---------------- randomized run with model ----------------
        do_reset();
        exp_pc = RST_PC; wcnt = 0; lat = $urandom_range(0, 3);
        pend = 1'b0; pend_addr = 32'h0; rnd_waits = 0; delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                chk("rnd_perf_mid", perf_wait_cnt, perf_expect(rnd_waits));
                do_reset();
                exp_pc = RST_PC; wcnt = 0; lat = $urandom_range(0, 3);
                pend = 1'b0; rnd_waits = 0;
            end
            @(negedge clk);
            stall_d     = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
            rv          = imem.req && (wcnt >= lat);
            imem.rvalid = rv;
            imem.rdata  = mem_word(imem.addr);
            #1;
            if (pend) begin
                chk("r_hold_req", {31'h0, imem.req}, 32'h1);
                chk("r_hold_addr", imem.addr, pend_addr);
            end
            if (redirect) begin
                chk("r_redir_clr", {31'h0, fd_clr}, 32'h1);
                chk("r_redir_en", {31'h0, fd_en}, 32'h0);
            end else if (stall_d) begin
                chk("r_stall_en", {31'h0, fd_en}, 32'h0);
                chk("r_stall_clr", {31'h0, fd_clr}, 32'h0);
            end else begin
                chk("r_en_xor_clr", {31'h0, fd_en ^ fd_clr}, 32'h1);
            end
            if (fd_en) begin
                chk("r_pcf", pcf, exp_pc);
                chk("r_instr", instr_f, mem_word(exp_pc));
                chk("r_pc4", pc_plus_4f, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (redirect)
                exp_pc = redirect_pc;
            if (imem.req && rv) begin
                wcnt = 0;
                lat  = $urandom_range(0, 3);
            end else if (imem.req) begin
                wcnt++;
            end else begin
                wcnt = 0;
            end
            if (imem.req && !rv)
                rnd_waits++;
            pend      = imem.req && !rv;
            pend_addr = imem.addr;
        end
        #1;
        chk("rnd_perf_end", perf_wait_cnt, perf_expect(rnd_waits));
        chk("rnd_deliveries", {31'h0, (delivered >= 300)}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
